// File: rtl/seq_num_retire_unit_pkg.sv
// Shared types for the sequence-number retirement path.
// Optional build macro SEQ_NUM_RETIRE_CHECK_EN enables protocol checking in seq_num_retire_unit.
package SeqNumPkg;

    localparam int SEQ_NUM_BITS_DEFAULT = 5;

    // The in-flight count needs one extra bit so that full and empty are distinct.
    function automatic int count_bits(input int seq_bits);
        return seq_bits + 1;
    endfunction

    localparam int COUNT_BITS_DEFAULT = count_bits(SEQ_NUM_BITS_DEFAULT);

    typedef logic [SEQ_NUM_BITS_DEFAULT-1:0] seq_num_t;
    typedef logic [COUNT_BITS_DEFAULT-1:0]   count_t;

endpackage

// File: rtl/seq_num_retire_unit_if.sv
// Allocation snoop, completion and free bundle of the retirement unit.
// Optional build macro SEQ_NUM_RETIRE_CHECK_EN adds the sticky err signal.
interface seq_num_retire_unit_if
    import SeqNumPkg::*;
#(
    parameter int p_seq_num_bits = SEQ_NUM_BITS_DEFAULT
);

    logic                      alloc_val;
    logic                      alloc_rdy;
    logic [p_seq_num_bits-1:0] alloc_seq_num;
    logic                      complete_val;
    logic [p_seq_num_bits-1:0] complete_seq_num;
    logic                      free_val;
    logic [p_seq_num_bits-1:0] free_seq_num;
    logic [p_seq_num_bits:0]   num_inflight;
`ifdef SEQ_NUM_RETIRE_CHECK_EN
    logic                      err;
`endif

    modport master (
        output alloc_val,
        output alloc_rdy,
        output alloc_seq_num,
        output complete_val,
        output complete_seq_num,
        input  free_val,
        input  free_seq_num,
`ifdef SEQ_NUM_RETIRE_CHECK_EN
        input  err,
`endif
        input  num_inflight
    );

    modport slave (
        input  alloc_val,
        input  alloc_rdy,
        input  alloc_seq_num,
        input  complete_val,
        input  complete_seq_num,
        output free_val,
        output free_seq_num,
`ifdef SEQ_NUM_RETIRE_CHECK_EN
        output err,
`endif
        output num_inflight
    );

endinterface

// File: rtl/seq_num_retire_unit_done_table.sv
// Per-entry completion bits: one set port, two clear ports (clear beats set), one read port.
// With SEQ_NUM_RETIRE_CHECK_EN a second read port feeds the completion checker.
module seq_num_done_table
    import SeqNumPkg::*;
#(
    parameter int p_seq_num_bits = SEQ_NUM_BITS_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      set_en,
    input  logic [p_seq_num_bits-1:0] set_idx,
    input  logic                      clr_a_en,
    input  logic [p_seq_num_bits-1:0] clr_a_idx,
    input  logic                      clr_b_en,
    input  logic [p_seq_num_bits-1:0] clr_b_idx,
    input  logic [p_seq_num_bits-1:0] rd_idx,
`ifdef SEQ_NUM_RETIRE_CHECK_EN
    input  logic [p_seq_num_bits-1:0] chk_idx,
    output logic                      chk_done,
`endif
    output logic                      rd_done
);

    localparam int ENTRIES = 1 << p_seq_num_bits;

    logic [ENTRIES-1:0] done_q;
    logic [ENTRIES-1:0] done_d;

    // Clears are applied after the set so a new allocation always starts not-done.
    always_comb begin
        done_d = done_q;
        if (set_en) begin
            done_d[set_idx] = 1'b1;
        end
        if (clr_a_en) begin
            done_d[clr_a_idx] = 1'b0;
        end
        if (clr_b_en) begin
            done_d[clr_b_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= '0;
        end else begin
            done_q <= done_d;
        end
    end

    assign rd_done = done_q[rd_idx];
`ifdef SEQ_NUM_RETIRE_CHECK_EN
    assign chk_done = done_q[chk_idx];
`endif

endmodule

// File: rtl/seq_num_retire_unit.sv
// In-order retirement tracker: frees sequence numbers in allocation order once completed.
// Optional build macro SEQ_NUM_RETIRE_CHECK_EN adds the sticky protocol error output bus.err.
module seq_num_retire_unit
    import SeqNumPkg::*;
#(
    parameter int p_seq_num_bits = SEQ_NUM_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_num_retire_unit_if.slave bus
);

    typedef logic [p_seq_num_bits-1:0]              seq_t;
    typedef logic [count_bits(p_seq_num_bits)-1:0]  cnt_t;

    seq_t head_q;
    seq_t head_d;
    seq_t tail_q;
    seq_t tail_d;
    cnt_t inflight_q;
    cnt_t inflight_d;

    logic alloc_fire;
    logic head_done;
    logic free_fire;

    assign alloc_fire = bus.alloc_val && bus.alloc_rdy;
    assign free_fire  = (inflight_q != '0) && head_done;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = inflight_q;
        if (alloc_fire) begin
            tail_d = tail_q + 1'b1;
        end
        if (free_fire) begin
            head_d = head_q + 1'b1;
        end
        case ({alloc_fire, free_fire})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            inflight_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef SEQ_NUM_RETIRE_CHECK_EN
    logic cmpl_done;
`endif

    seq_num_done_table #(
        .p_seq_num_bits (p_seq_num_bits)
    ) u_done_table (
        .clk       (clk),
        .rst       (rst),
        .set_en    (bus.complete_val),
        .set_idx   (bus.complete_seq_num),
        .clr_a_en  (alloc_fire),
        .clr_a_idx (bus.alloc_seq_num),
        .clr_b_en  (free_fire),
        .clr_b_idx (head_q),
        .rd_idx    (head_q),
`ifdef SEQ_NUM_RETIRE_CHECK_EN
        .chk_idx   (bus.complete_seq_num),
        .chk_done  (cmpl_done),
`endif
        .rd_done   (head_done)
    );

    assign bus.free_val     = free_fire;
    assign bus.free_seq_num = head_q;
    assign bus.num_inflight = inflight_q;

`ifdef SEQ_NUM_RETIRE_CHECK_EN
    localparam int ENTRIES = 1 << p_seq_num_bits;

    logic err_q;
    logic err_d;
    seq_t cmpl_ofs;
    logic bad_alloc;
    logic bad_cmpl;

    // An entry is in flight when its distance from head is below the count.
    always_comb begin
        err_d     = err_q;
        cmpl_ofs  = bus.complete_seq_num - head_q;
        bad_alloc = alloc_fire &&
                    ((bus.alloc_seq_num != tail_q) || (inflight_q == cnt_t'(ENTRIES)));
        bad_cmpl  = bus.complete_val &&
                    (({1'b0, cmpl_ofs} >= inflight_q) || cmpl_done);
        if (bad_alloc || bad_cmpl) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_seq_num_retire_unit.sv
// Directed bench for seq_num_retire_unit with a free-order scoreboard.
// Define SEQ_NUM_RETIRE_CHECK_EN to also exercise the err output.
module tb_seq_num_retire_unit;
    import SeqNumPkg::*;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    typedef struct {
        int seq;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    seq_num_retire_unit_if #(.p_seq_num_bits(SEQ_NUM_BITS_DEFAULT)) bus ();

    seq_num_retire_unit #(
        .p_seq_num_bits (SEQ_NUM_BITS_DEFAULT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, need completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Expected free of seq, delay cycles after the cycle currently being driven.
    task automatic expect_free(input int seq, input int delay);
        exp_t e;
        e.seq = seq;
        e.cyc = cyc + delay;
        exp_q.push_back(e);
    endtask

    // Drives one cycle of inputs; exp_cnt is the registered count for that cycle (-1 skips).
    task automatic apply_stimulus(input bit av, input bit ar, input int an,
                                  input bit cv, input int cn, input int exp_cnt);
        @(posedge clk);
        #1;
        bus.alloc_val        = av;
        bus.alloc_rdy        = ar;
        bus.alloc_seq_num    = an[4:0];
        bus.complete_val     = cv;
        bus.complete_seq_num = cn[4:0];
        if (exp_cnt >= 0) begin
            check_output("num_inflight", int'(bus.num_inflight), exp_cnt);
        end
    endtask

    task automatic alloc(input int n, input int exp_cnt);
        apply_stimulus(1'b1, 1'b1, n, 1'b0, 0, exp_cnt);
    endtask

    task automatic complete(input int n, input int exp_cnt);
        apply_stimulus(1'b0, 1'b0, 0, 1'b1, n, exp_cnt);
    endtask

    task automatic idle(input int exp_cnt);
        apply_stimulus(1'b0, 1'b0, 0, 1'b0, 0, exp_cnt);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst                  = 1'b1;
        bus.alloc_val        = 1'b0;
        bus.alloc_rdy        = 1'b0;
        bus.alloc_seq_num    = '0;
        bus.complete_val     = 1'b0;
        bus.complete_seq_num = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every free must match the head of the scoreboard in value and cycle.
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL missed_free: got no free of %0d, expected at cycle %0d (now %0d)",
                         exp_q[0].seq, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (bus.free_val) begin
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    check_output("free_seq_num", int'(bus.free_seq_num), exp_q[0].seq);
                    void'(exp_q.pop_front());
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_free: got free of %0d at cycle %0d, expected none",
                             bus.free_seq_num, cyc);
                end
            end
        end
    end

    initial begin
        n_checks             = 0;
        n_fail               = 0;
        rst                  = 1'b1;
        bus.alloc_val        = 1'b0;
        bus.alloc_rdy        = 1'b0;
        bus.alloc_seq_num    = '0;
        bus.complete_val     = 1'b0;
        bus.complete_seq_num = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check_output("reset_free_val", int'(bus.free_val), 0);
        check_output("reset_free_seq_num", int'(bus.free_seq_num), 0);
        check_output("reset_num_inflight", int'(bus.num_inflight), 0);

        // Basic in-order; a valid without ready must not allocate.
        apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 0);
        alloc(0, 0);
        alloc(1, 1);
        complete(0, 2);  expect_free(0, 1);
        complete(1, 2);  expect_free(1, 1);
        idle(1);
        idle(0);

        // Out-of-order completion held behind the head.
        do_reset();
        alloc(0, 0);
        alloc(1, 1);
        alloc(2, 2);
        complete(2, 3);
        complete(1, 3);
        idle(3);
        complete(0, 3);
        expect_free(0, 1);
        expect_free(1, 2);
        expect_free(2, 3);
        idle(3);
        idle(2);
        idle(1);
        idle(0);

        // Allocation in the same cycle as a free.
        do_reset();
        alloc(0, 0);
        alloc(1, 1);
        alloc(2, 2);
        complete(0, 3);  expect_free(0, 1);
        alloc(3, 3);
        idle(3);
        complete(1, 3);  expect_free(1, 1);
        complete(2, 3);  expect_free(2, 1);
        complete(3, 2);  expect_free(3, 1);
        idle(1);
        idle(0);

        // Wrap-around: 40 allocate/complete pairs.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(1'b1, 1'b1, i % 32, i > 0, (i + 31) % 32, (i < 2) ? i : 2);
            if (i > 0) expect_free((i + 31) % 32, 1);
        end
        complete(7, 2);  expect_free(7, 1);
        idle(1);
        idle(0);

        // Full: 32 in flight, nothing done.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            alloc(i, i);
        end
        idle(32);
        check_output("full_free_val", int'(bus.free_val), 0);
        complete(0, 32); expect_free(0, 1);
        idle(32);
        idle(31);

        // Reset mid-run discards state, including a completion of head on the reset edge.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc(i, i);
        end
        complete(3, 5);
        complete(4, 5);
        @(posedge clk);
        #1;
        rst                  = 1'b1;
        bus.alloc_val        = 1'b0;
        bus.alloc_rdy        = 1'b0;
        bus.complete_val     = 1'b1;
        bus.complete_seq_num = 5'd0;
        @(posedge clk);
        #1;
        rst              = 1'b0;
        bus.complete_val = 1'b0;
        check_output("post_reset_free_val", int'(bus.free_val), 0);
        check_output("post_reset_num_inflight", int'(bus.num_inflight), 0);
        alloc(0, 0);
        complete(0, 1);  expect_free(0, 1);
        idle(1);
        idle(0);

`ifdef SEQ_NUM_RETIRE_CHECK_EN
        do_reset();
        idle(0);
        check_output("err_idle", int'(bus.err), 0);
        complete(7, 0);
        idle(0);
        check_output("err_set", int'(bus.err), 1);
        idle(0);
        check_output("err_sticky", int'(bus.err), 1);
        do_reset();
        check_output("err_cleared", int'(bus.err), 0);
`endif

        repeat (3) idle(0);
        check_output("pending_frees", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_num_retire_unit.md
# seq_num_retire_unit

In-order retirement tracker that sits directly downstream of the sequencing unit. It snoops every sequence number the sequencing unit hands out, accepts out-of-order completion notices from execution, and returns numbers to the sequencing unit's free interface strictly in allocation order, one per cycle. It drives the `free` side of the sequencing unit; its allocation input is the same `alloc` handshake the sequencing unit produces.

## Interface

- `p_seq_num_bits`, 5: width of a sequence number; the tracked space is 2^`p_seq_num_bits` entries.
- `clk` in 1: clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `alloc_val` in 1: allocation handshake valid, from the sequencing unit.
- `alloc_rdy` in 1: allocation handshake ready, from the consumer; allocation fires when `alloc_val && alloc_rdy`.
- `alloc_seq_num` in `p_seq_num_bits`: number being allocated.
- `complete_val` in 1: completion notice; no back-pressure.
- `complete_seq_num` in `p_seq_num_bits`: number that has finished executing.
- `free_val` out 1: a number is being freed this cycle; no back-pressure.
- `free_seq_num` out `p_seq_num_bits`: number being freed; always the oldest in-flight number.
- `num_inflight` out `p_seq_num_bits`+1: count of allocated-but-not-freed numbers.

## Operation

- State: `head` pointer (oldest in-flight), `tail` pointer (next expected allocation), `inflight` count, per-entry `done` bit.
- Reset: `head`=0, `tail`=0, `inflight`=0, all `done`=0. Outputs after reset: `free_val`=0, `free_seq_num`=0, `num_inflight`=0.
- Allocation fire: clear `done[alloc_seq_num]`, `tail`++ (mod 2^bits), `inflight`++.
- Completion: set `done[complete_seq_num]`.
- Free: `free_val` = (`inflight` != 0) && `done[head]`; `free_seq_num` = `head`. On a free cycle, `head`++ (mod 2^bits), `inflight`--, clear `done[head]`.
- Simultaneous allocation and free: `inflight` unchanged; both pointers advance.
- Simultaneous completion and allocation of the same index: allocation wins (`done` cleared). This case is illegal upstream.
- Full: `inflight` reaches 2^bits. The block keeps tracking; throttling is the sequencing unit's job.
- Wrap-around: pointers wrap modulo 2^bits with no special handling. The count disambiguates full from empty.

## Timing

- Completion to free: 1 cycle. A completion registered at edge N can drive `free_val` in cycle N+1, provided it is `head`. There is no same-cycle bypass.
- Cascaded completions free at one per cycle, starting the cycle after the head completes.
- Allocation to `num_inflight` update: 1 cycle (registered).
- `free_val`/`free_seq_num` are combinational from registered state only. They have no combinational path from any input.
- A reset asserted mid-operation discards all in-flight state on that edge. `free_val` is 0 in the following cycle.

## Configuration

- `SEQ_NUM_RETIRE_CHECK_EN` defined: adds output `err` (1 bit, reset 0), which is sticky until reset. It is set on any of:
  - an allocation with `alloc_seq_num` != `tail`;
  - an allocation with `inflight` == 2^bits;
  - a completion of an entry not in flight;
  - a completion of an entry already `done`.
- The offending event is still applied to state as described in Operation.
- Not defined: `err` port absent; illegal events are applied silently with no checking logic.

## Structure

- Shared package `SeqNumPkg`: typedef for sequence number (parameterised by width via a localparam helper), `count_t` width rule (bits+1).
- Sub-module `seq_num_done_table`: 2^bits-entry bit array with one set port (completion), two clear ports (allocation, free) and one read port (`head`). Clear takes priority over set.
- Top level holds the pointers, count, free logic and optional check logic.

## Test plan

- Basic in-order: allocate 0,1; complete 0, then 1 on the next cycle → frees 0 then 1 on consecutive cycles; `num_inflight` goes 2→1→0.
- Out-of-order: allocate 0,1,2; complete 2, then 1 → no free; complete 0 → frees 0,1,2 in three consecutive cycles starting one cycle after that completion.
- Simultaneous: with 3 in flight and head done, fire an allocation in the same cycle as the free → `num_inflight` stays 3; `tail` and `head` both advance.
- Wrap-around (bits=5): cycle through 40 allocate/complete pairs → frees 0..31 then 0..7 in order; no stall at the wrap.
- Full: allocate 32 with none complete → `num_inflight`=32, `free_val`=0; complete 0 → free 0, count 31.
- Reset mid-run with 5 in flight, 2 done → next cycle `free_val`=0, `num_inflight`=0. With `SEQ_NUM_RETIRE_CHECK_EN`: completing 7 when not in flight → `err`=1, held until reset.
